// File: rtl/axil_router_wr.sv
// axil_router_wr
//   Registered AXI-Lite write-channel router. Accepts one AW+W pair from the
//   master port and decodes the address against NUMBER_SLAVE windows. A mapped
//   write is forwarded to the selected slave, and that slave's B response is
//   returned. An unmapped write is answered locally with DECERR, and no slave
//   sees it. Only one transaction is outstanding at a time.
//
// Ports
//   aclk, aresetn          clock, async active-low reset
//   m_axil_aw*/w*/b*       master-side AW/W/B channels
//   s_axil_awaddr/wdata/
//   s_axil_wstrb           latched payload, shared by all slaves
//   s_axil_awvalid/wvalid/
//   s_axil_bready          per-slave handshake outputs (one-hot)
//   s_axil_awready/wready/
//   s_axil_bvalid/bresp    per-slave handshake inputs; slave i bresp at [2i+1:2i]
//   busy                   high whenever a transaction is in flight
//   decerr_cnt             saturating count of DECERR responses
module axil_router_wr #(
  parameter int unsigned NUMBER_SLAVE   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = '{default: '0},
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] = '{default: AXI_ADDR_WIDTH'(1)},
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
  input  logic                          m_axil_awvalid,
  output logic                          m_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  input  logic                          m_axil_wvalid,
  output logic                          m_axil_wready,
  output logic [1:0]                    m_axil_bresp,
  output logic                          m_axil_bvalid,
  input  logic                          m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  output logic [NUMBER_SLAVE-1:0]       s_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  output logic [NUMBER_SLAVE-1:0]       s_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_wready,
  input  logic [2*NUMBER_SLAVE-1:0]     s_axil_bresp,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_bvalid,
  output logic [NUMBER_SLAVE-1:0]       s_axil_bready,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          decerr_cnt
);

  typedef enum logic [1:0] {IDLE, SLV_REQ, SLV_RESP, MST_RESP} state_t;

  state_t                        state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0]     addr_r;
  logic [AXI_DATA_WIDTH-1:0]     data_r;
  logic [AXI_DATA_WIDTH/8-1:0]   strb_r;
  logic [NUMBER_SLAVE-1:0]       sel_r;
  logic [NUMBER_SLAVE-1:0]       hit;
  logic [1:0]                    bresp_r, slv_bresp;
  logic                          aw_done, w_done, aw_done_nxt, w_done_nxt;
  logic                          accept, aw_hs, w_hs, found;

  // Window compare is done one bit wider than the address so that a window
  // ending at the top of the address space does not wrap back to zero.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUMBER_SLAVE; i++) begin
      if (!found &&
          ({1'b0, m_axil_awaddr} >= {1'b0, AXI_ADDR_OFFSET[i]}) &&
          (({1'b0, m_axil_awaddr} - {1'b0, AXI_ADDR_OFFSET[i]}) < {1'b0, AXI_ADDR_RANGE[i]})) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    slv_bresp = 2'b00;
    for (int unsigned i = 0; i < NUMBER_SLAVE; i++) begin
      if (sel_r[i]) slv_bresp = s_axil_bresp[2*i +: 2];
    end
  end

  always_comb begin
    state_nxt      = state;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;
    accept         = 1'b0;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    s_axil_awvalid = '0;
    s_axil_wvalid  = '0;
    s_axil_bready  = '0;
    m_axil_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so the combinational readies stay low while held in reset.
        accept = aresetn && m_axil_awvalid && m_axil_wvalid;
        if (accept) state_nxt = (hit == '0) ? MST_RESP : SLV_REQ;
      end
      SLV_REQ: begin
        s_axil_awvalid = aw_done ? '0 : sel_r;
        s_axil_wvalid  = w_done  ? '0 : sel_r;
        aw_hs = |(s_axil_awvalid & s_axil_awready);
        w_hs  = |(s_axil_wvalid  & s_axil_wready);
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt   = SLV_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done || aw_hs;
          w_done_nxt  = w_done  || w_hs;
        end
      end
      SLV_RESP: begin
        s_axil_bready = sel_r;
        if (|(sel_r & s_axil_bvalid)) state_nxt = MST_RESP;
      end
      MST_RESP: begin
        m_axil_bvalid = 1'b1;
        if (m_axil_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      addr_r     <= '0;
      data_r     <= '0;
      strb_r     <= '0;
      sel_r      <= '0;
      bresp_r    <= 2'b00;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      decerr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (accept) begin
        addr_r <= m_axil_awaddr;
        data_r <= m_axil_wdata;
        strb_r <= m_axil_wstrb;
        sel_r  <= hit;
        if (hit == '0) begin
          bresp_r <= 2'b11;
          if (decerr_cnt != '1) decerr_cnt <= decerr_cnt + 1'b1;
        end
      end
      if (state == SLV_RESP && (|(sel_r & s_axil_bvalid))) bresp_r <= slv_bresp;
    end
  end

  assign m_axil_awready = accept;
  assign m_axil_wready  = accept;
  assign m_axil_bresp   = bresp_r;
  assign s_axil_awaddr  = addr_r;
  assign s_axil_wdata   = data_r;
  assign s_axil_wstrb   = strb_r;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_axil_router_wr.sv
// Testbench for axil_router_wr: directed writes with a scoreboard that holds
// expected slave-side AW/W payloads and master-side B responses. These are
// checked by a monitor that is independent of the stimulus.
module tb_axil_router_wr;

  localparam int unsigned NS = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = 2;
  localparam logic [AW-1:0] OFFS [NS] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000,
                                          32'h0000_3000, 32'hFFFF_F000};
  localparam logic [AW-1:0] RNGS [NS] = '{default: 32'h0000_1000};

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [AW-1:0]   m_awaddr;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wvalid, m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;
  logic [AW-1:0]   s_awaddr;
  logic [NS-1:0]   s_awvalid, s_awready;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [NS-1:0]   s_wvalid, s_wready;
  logic [2*NS-1:0] s_bresp;
  logic [NS-1:0]   s_bvalid, s_bready;
  logic            busy;
  logic [CW-1:0]   decerr_cnt;

  always #5 aclk = ~aclk;

  axil_router_wr #(
    .NUMBER_SLAVE    (NS),
    .AXI_ADDR_WIDTH  (AW),
    .AXI_DATA_WIDTH  (DW),
    .AXI_ADDR_OFFSET (OFFS),
    .AXI_ADDR_RANGE  (RNGS),
    .CNT_WIDTH       (CW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .m_axil_awaddr  (m_awaddr),
    .m_axil_awvalid (m_awvalid),
    .m_axil_awready (m_awready),
    .m_axil_wdata   (m_wdata),
    .m_axil_wstrb   (m_wstrb),
    .m_axil_wvalid  (m_wvalid),
    .m_axil_wready  (m_wready),
    .m_axil_bresp   (m_bresp),
    .m_axil_bvalid  (m_bvalid),
    .m_axil_bready  (m_bready),
    .s_axil_awaddr  (s_awaddr),
    .s_axil_awvalid (s_awvalid),
    .s_axil_awready (s_awready),
    .s_axil_wdata   (s_wdata),
    .s_axil_wstrb   (s_wstrb),
    .s_axil_wvalid  (s_wvalid),
    .s_axil_wready  (s_wready),
    .s_axil_bresp   (s_bresp),
    .s_axil_bvalid  (s_bvalid),
    .s_axil_bready  (s_bready),
    .busy           (busy),
    .decerr_cnt     (decerr_cnt)
  );

  typedef struct { int idx; logic [AW-1:0] addr; } aw_exp_t;
  typedef struct { int idx; logic [DW-1:0] data; logic [SW-1:0] strb; } w_exp_t;

  aw_exp_t    exp_aw[$];
  w_exp_t     exp_w[$];
  logic [1:0] exp_b[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: samples just after the falling edge, when inputs are settled for
  // the next rising edge, so every handshake seen here completes on that edge.
  initial begin
    aw_exp_t e_aw;
    w_exp_t  e_w;
    forever begin
      @(negedge aclk);
      #1;
      if (aresetn) begin
        if (s_awvalid != '0) check("aw_onehot", $countones(s_awvalid), 1);
        for (int i = 0; i < NS; i++) begin
          if (s_awvalid[i] && s_awready[i]) begin
            if (exp_aw.size() == 0) check("aw_unexpected_slave", i, NS);
            else begin
              e_aw = exp_aw.pop_front();
              check("aw_slave", i, e_aw.idx);
              check("aw_addr", s_awaddr, e_aw.addr);
            end
          end
          if (s_wvalid[i] && s_wready[i]) begin
            if (exp_w.size() == 0) check("w_unexpected_slave", i, NS);
            else begin
              e_w = exp_w.pop_front();
              check("w_slave", i, e_w.idx);
              check("w_data", s_wdata, e_w.data);
              check("w_strb", s_wstrb, e_w.strb);
            end
          end
        end
        if (m_bvalid && m_bready) begin
          if (exp_b.size() == 0) check("b_unexpected", m_bresp, 4);
          else check("m_bresp", m_bresp, exp_b.pop_front());
        end
      end
    end
  end

  task automatic set_bresp(input int i, input logic [1:0] v);
    s_bresp[2*i +: 2] = v;
  endtask

  // Presents AW+W together until accepted, then drops them on the next
  // falling edge (cycle 1 relative to the accept cycle).
  task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] st, input int idx,
                             input logic [1:0] b, input bit push);
    @(negedge aclk);
    m_awaddr = a; m_wdata = d; m_wstrb = st;
    m_awvalid = 1'b1; m_wvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (m_awready) break;
      @(negedge aclk);
    end
    check("accept_awready", m_awready, 1);
    check("accept_wready", m_wready, 1);
    if (push) begin
      if (idx >= 0) begin
        exp_aw.push_back('{idx: idx, addr: a});
        exp_w.push_back('{idx: idx, data: d, strb: st});
      end
      exp_b.push_back(b);
    end
    @(negedge aclk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge aclk);
      #1;
      if (!busy) break;
    end
    check("idle_timeout", busy, 0);
  endtask

  logic [AW-1:0] t3_addr [6] = '{32'h0000_0FFF, 32'h0000_1000, 32'h0000_3FFF,
                                 32'h0000_4000, 32'hFFFF_FFFF, 32'hFFFF_EFFF};
  int            t3_idx  [6] = '{0, 1, 3, -1, 4, -1};

  initial begin
    aresetn = 1'b0;
    m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
    m_bready = 1'b1;
    s_awready = '1; s_wready = '1; s_bvalid = '1; s_bresp = '0;

    // Reset state, with the master already offering a write.
    repeat (2) @(negedge aclk);
    m_awvalid = 1'b1; m_wvalid = 1'b1;
    #1;
    check("rst_awready", m_awready, 0);
    check("rst_busy", busy, 0);
    check("rst_m_bvalid", m_bvalid, 0);
    check("rst_m_bresp", m_bresp, 0);
    check("rst_s_awvalid", s_awvalid, 0);
    check("rst_s_wvalid", s_wvalid, 0);
    check("rst_s_bready", s_bready, 0);
    check("rst_s_awaddr", s_awaddr, 0);
    check("rst_decerr_cnt", decerr_cnt, 0);
    @(negedge aclk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    aresetn = 1'b1;

    // T1: mapped write to slave1 with latency checks.
    start_write(32'h0000_1004, 32'hA5A5_A5A5, 4'hF, 1, 2'b00, 1'b1);
    #1;
    check("t1_c1_awvalid", s_awvalid, 5'b00010);
    check("t1_c1_wvalid", s_wvalid, 5'b00010);
    check("t1_c1_awaddr", s_awaddr, 32'h0000_1004);
    check("t1_c1_wdata", s_wdata, 32'hA5A5_A5A5);
    check("t1_c1_m_bvalid", m_bvalid, 0);
    @(negedge aclk); #1;
    check("t1_c2_bready", s_bready, 5'b00010);
    check("t1_c2_awvalid", s_awvalid, 0);
    @(negedge aclk); #1;
    check("t1_c3_m_bvalid", m_bvalid, 1);
    check("t1_c3_m_bresp", m_bresp, 2'b00);
    wait_idle();

    // T2: unmapped write terminated locally.
    check("t2_cnt_before", decerr_cnt, 0);
    start_write(32'h0000_8000, 32'h1234_5678, 4'hF, -1, 2'b11, 1'b1);
    #1;
    check("t2_c1_m_bvalid", m_bvalid, 1);
    check("t2_c1_m_bresp", m_bresp, 2'b11);
    check("t2_c1_awvalid", s_awvalid, 0);
    check("t2_c1_wvalid", s_wvalid, 0);
    check("t2_cnt_after", decerr_cnt, 1);
    wait_idle();

    // T3: window boundaries, including the top-of-space window.
    for (int k = 0; k < 6; k++) begin
      start_write(t3_addr[k], t3_addr[k] ^ 32'h5A5A_0000, 4'h5, t3_idx[k],
                  (t3_idx[k] < 0) ? 2'b11 : 2'b00, 1'b1);
      wait_idle();
    end
    check("t3_cnt", decerr_cnt, 3);

    // T4: AW alone is never accepted; AW and W handshakes complete independently.
    s_wready[0] = 1'b0;
    set_bresp(0, 2'b10);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      m_awaddr = 32'h0000_0010; m_awvalid = 1'b1; m_wvalid = 1'b0;
      #1;
      check("t4_aw_alone_awready", m_awready, 0);
      check("t4_aw_alone_busy", busy, 0);
    end
    start_write(32'h0000_0010, 32'hCAFE_F00D, 4'h3, 0, 2'b10, 1'b1);
    #1;
    check("t4_c1_awvalid", s_awvalid, 5'b00001);
    check("t4_c1_wvalid", s_wvalid, 5'b00001);
    @(negedge aclk); #1;
    check("t4_c2_awvalid", s_awvalid, 0);
    check("t4_c2_wvalid", s_wvalid, 5'b00001);
    @(negedge aclk); #1;
    check("t4_c3_wvalid", s_wvalid, 5'b00001);
    @(negedge aclk);
    s_wready[0] = 1'b1;
    #1;
    check("t4_c4_wvalid", s_wvalid, 5'b00001);
    @(negedge aclk); #1;
    check("t4_c5_wvalid", s_wvalid, 0);
    check("t4_c5_bready", s_bready, 5'b00001);
    wait_idle();
    set_bresp(0, 2'b00);

    // T5: master B back-pressure; a waiting write is held off until after B.
    set_bresp(2, 2'b01);
    m_bready = 1'b0;
    start_write(32'h0000_2000, 32'h0BAD_BEEF, 4'hC, 2, 2'b01, 1'b1);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (m_bvalid) break;
      @(negedge aclk);
    end
    check("t5_bvalid_seen", m_bvalid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      m_awaddr = 32'h0000_3004; m_wdata = 32'h0F0F_0F0F; m_wstrb = 4'hF;
      m_awvalid = 1'b1; m_wvalid = 1'b1;
      #1;
      check("t5_hold_bvalid", m_bvalid, 1);
      check("t5_hold_bresp", m_bresp, 2'b01);
      check("t5_hold_awready", m_awready, 0);
    end
    @(negedge aclk);
    m_bready = 1'b1;
    #1;
    check("t5_b_cycle_awready", m_awready, 0);
    @(negedge aclk); #1;
    check("t5_next_accept", m_awready, 1);
    exp_aw.push_back('{idx: 3, addr: 32'h0000_3004});
    exp_w.push_back('{idx: 3, data: 32'h0F0F_0F0F, strb: 4'hF});
    exp_b.push_back(2'b00);
    @(negedge aclk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    wait_idle();
    set_bresp(2, 2'b00);

    // T6: counter saturation, then reset in the middle of a slave request.
    start_write(32'h0000_5000, 32'h0, 4'h1, -1, 2'b11, 1'b1);
    wait_idle();
    check("t6_sat_4", decerr_cnt, 3);
    start_write(32'h7FFF_0000, 32'h0, 4'h1, -1, 2'b11, 1'b1);
    wait_idle();
    check("t6_sat_5", decerr_cnt, 3);

    s_awready = '0; s_wready = '0;
    start_write(32'h0000_1000, 32'hDEAD_0001, 4'hF, 1, 2'b00, 1'b0);
    #1;
    check("t6_req_awvalid", s_awvalid, 5'b00010);
    check("t6_req_busy", busy, 1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_awvalid", s_awvalid, 0);
    check("t6_rst_wvalid", s_wvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_m_bvalid", m_bvalid, 0);
    check("t6_rst_cnt", decerr_cnt, 0);
    check("t6_rst_awaddr", s_awaddr, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    s_awready = '1; s_wready = '1;
    start_write(32'h0000_0004, 32'h7777_8888, 4'hF, 0, 2'b00, 1'b1);
    wait_idle();
    check("t6_recover_cnt", decerr_cnt, 0);

    repeat (3) @(negedge aclk);
    check("end_exp_aw_empty", exp_aw.size(), 0);
    check("end_exp_w_empty", exp_w.size(), 0);
    check("end_exp_b_empty", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
